// File: rtl/down_cnt4_rle_pkg.sv
// rtl/down_cnt4_rle_pkg.sv - shared width constant and FSM state type for the down counter
package down_cnt4_rle_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage

// File: rtl/down_cnt4_rle.sv
// rtl/down_cnt4_rle.sv - cascadable down counter with reload register and one-shot halt
module down_cnt4_rle
    import down_cnt4_rle_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             R,
    input  logic             ce,
    input  logic             L,
    input  logic [WIDTH-1:0] di,
    input  logic             mode,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             CEO,
    output logic             done
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_n;
    logic [WIDTH-1:0] rld;
    logic [WIDTH-1:0] rld_n;
    logic             done_r;
    logic             done_n;

    // State register: reset wins over everything, otherwise take the computed next state.
    always_ff @(posedge clk) begin
        if (!R) begin
            cnt    <= '0;
            rld    <= '1;
            state  <= RUN;
            done_r <= 1'b0;
        end else begin
            cnt    <= cnt_n;
            rld    <= rld_n;
            state  <= state_n;
            done_r <= done_n;
        end
    end

    // Next state: load beats count; counting only in RUN; mode matters only at the zero event.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rld_n   = rld;
        done_n  = done_r;
        if (L) begin
            cnt_n   = di;
            rld_n   = di;
            state_n = RUN;
            done_n  = 1'b0;
        end else if (ce && (state == RUN)) begin
            if (cnt != '0) begin
                cnt_n = cnt - WIDTH'(1);
            end else if (!mode) begin
                cnt_n = rld;
            end else begin
                state_n = HALT;
                done_n  = 1'b1;
            end
        end
    end

    // Outputs: terminal count and cascade enable are combinational so the next stage sees them this cycle.
    always_comb begin
        Q    = cnt;
        done = done_r;
        TC   = (cnt == '0);
        CEO  = ce & TC & (state == RUN);
    end

endmodule

// File: tb/tb_down_cnt4_rle.sv
// tb/tb_down_cnt4_rle.sv - scoreboard bench for down_cnt4_rle, single stage and two-stage cascade
module tb_down_cnt4_rle;

    logic       clk;
    logic       R;
    logic       ce;
    logic       L;
    logic [3:0] di;
    logic       mode;
    logic [3:0] Q;
    logic       TC;
    logic       CEO;
    logic       done;

    logic       cr;
    logic       cce0;
    logic [3:0] cq0;
    logic [3:0] cq1;
    logic       ctc0;
    logic       ctc1;
    logic       cceo0;
    logic       cceo1;
    logic       cdone0;
    logic       cdone1;

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       ceo;
        logic       done;
    } exp_t;

    exp_t       main_q[$];
    logic [7:0] casc_q[$];
    int         n_pass;
    int         n_total;

    down_cnt4_rle #(.WIDTH(4)) dut (
        .clk(clk), .R(R), .ce(ce), .L(L), .di(di), .mode(mode),
        .Q(Q), .TC(TC), .CEO(CEO), .done(done)
    );

    down_cnt4_rle #(.WIDTH(4)) c0 (
        .clk(clk), .R(cr), .ce(cce0), .L(1'b0), .di(4'd0), .mode(1'b0),
        .Q(cq0), .TC(ctc0), .CEO(cceo0), .done(cdone0)
    );

    down_cnt4_rle #(.WIDTH(4)) c1 (
        .clk(clk), .R(cr), .ce(cceo0), .L(1'b0), .di(4'd0), .mode(1'b0),
        .Q(cq1), .TC(ctc1), .CEO(cceo1), .done(cdone1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input logic r, input logic l, input logic c, input logic m,
                        input logic [3:0] d, input logic chk, input logic [3:0] eq,
                        input logic etc, input logic eceo, input logic edone);
        exp_t e;
        @(posedge clk);
        #1;
        R    = r;
        L    = l;
        ce   = c;
        mode = m;
        di   = d;
        if (chk) begin
            e.q    = eq;
            e.tc   = etc;
            e.ceo  = eceo;
            e.done = edone;
            main_q.push_back(e);
        end
    endtask

    task automatic cstep(input logic r, input logic c, input logic chk, input logic [7:0] ev);
        @(posedge clk);
        #1;
        cr   = r;
        cce0 = c;
        if (chk) casc_q.push_back(ev);
    endtask

    // Monitor: away from the active edge, pop and compare whatever is pending.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] v;
        if (main_q.size() > 0) begin
            e = main_q.pop_front();
            n_total++;
            if ({Q, TC, CEO, done} === e) n_pass++;
            else $display("FAIL main t=%0t got Q=%0d TC=%0b CEO=%0b done=%0b want Q=%0d TC=%0b CEO=%0b done=%0b",
                          $time, Q, TC, CEO, done, e.q, e.tc, e.ceo, e.done);
        end
        if (casc_q.size() > 0) begin
            v = casc_q.pop_front();
            n_total++;
            if ({cq1, cq0} === v) n_pass++;
            else $display("FAIL cascade t=%0t got %0d want %0d", $time, {cq1, cq0}, v);
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        R = 1'b0; L = 1'b0; ce = 1'b0; mode = 1'b0; di = 4'd0;
        cr = 1'b0; cce0 = 1'b0;

        // reset, then reset-state check with ce=0
        step(0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
        step(1, 0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0);
        // free-running from defaults: 0,15,14,...,1,0 then 15
        for (int k = 0; k < 17; k++) begin
            logic [3:0] q;
            q = (k == 0) ? 4'd0 : 4'(16 - k);
            step(1, 0, 1, 0, 4'd0, 1, q, q == 0, q == 0, 0);
        end
        step(1, 0, 0, 0, 4'd0, 1, 4'd15, 0, 0, 0);

        // load 5, auto-reload: 5,4,3,2,1,0 twice, CEO once per 6
        step(1, 1, 0, 0, 4'd5, 1, 4'd15, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            logic [3:0] q;
            q = 4'(5 - (k % 6));
            step(1, 0, 1, 0, 4'd0, 1, q, q == 0, q == 0, 0);
        end
        step(1, 0, 0, 0, 4'd0, 1, 4'd5, 0, 0, 0);

        // load 3 together with ce (no decrement), one-shot
        step(1, 1, 1, 1, 4'd3, 1, 4'd5, 0, 0, 0);
        step(1, 0, 1, 1, 4'd0, 1, 4'd3, 0, 0, 0);
        step(1, 0, 1, 1, 4'd0, 1, 4'd2, 0, 0, 0);
        step(1, 0, 1, 1, 4'd0, 1, 4'd1, 0, 0, 0);
        step(1, 0, 1, 1, 4'd0, 1, 4'd0, 1, 1, 0);
        step(1, 0, 1, 1, 4'd0, 1, 4'd0, 1, 0, 1);
        step(1, 0, 1, 0, 4'd0, 1, 4'd0, 1, 0, 1);
        // reload 2 from HALT; mode high away from zero has no effect
        step(1, 1, 1, 0, 4'd2, 1, 4'd0, 1, 0, 1);
        step(1, 0, 1, 1, 4'd0, 1, 4'd2, 0, 0, 0);
        step(1, 0, 1, 1, 4'd0, 1, 4'd1, 0, 0, 0);
        step(1, 0, 1, 0, 4'd0, 1, 4'd0, 1, 1, 0);
        step(1, 0, 1, 1, 4'd0, 1, 4'd2, 0, 0, 0);
        step(1, 0, 0, 0, 4'd0, 1, 4'd1, 0, 0, 0);

        // load 7, ce toggling
        step(1, 1, 0, 0, 4'd7, 1, 4'd1, 0, 0, 0);
        step(1, 0, 1, 0, 4'd0, 1, 4'd7, 0, 0, 0);
        step(1, 0, 0, 0, 4'd0, 1, 4'd6, 0, 0, 0);
        step(1, 0, 1, 0, 4'd0, 1, 4'd6, 0, 0, 0);
        step(1, 0, 0, 0, 4'd0, 1, 4'd5, 0, 0, 0);
        step(1, 0, 1, 0, 4'd0, 1, 4'd5, 0, 0, 0);
        step(1, 0, 0, 0, 4'd0, 1, 4'd4, 0, 0, 0);

        // reset at Q=4 with L=1 di=9 and ce=1: reset wins, RLD back to 15
        step(0, 1, 1, 0, 4'd9, 1, 4'd4, 0, 0, 0);
        step(1, 0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0);
        step(1, 0, 1, 0, 4'd0, 1, 4'd0, 1, 1, 0);
        step(1, 0, 0, 0, 4'd0, 1, 4'd15, 0, 0, 0);

        // divide-by-1
        step(1, 1, 0, 0, 4'd0, 1, 4'd15, 0, 0, 0);
        step(1, 0, 1, 0, 4'd0, 1, 4'd0, 1, 1, 0);
        step(1, 0, 1, 0, 4'd0, 1, 4'd0, 1, 1, 0);
        step(1, 0, 1, 0, 4'd0, 1, 4'd0, 1, 1, 0);
        step(1, 0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0);

        // reset out of HALT
        step(1, 1, 0, 1, 4'd1, 1, 4'd0, 1, 0, 0);
        step(1, 0, 1, 1, 4'd0, 1, 4'd1, 0, 0, 0);
        step(1, 0, 1, 1, 4'd0, 1, 4'd0, 1, 1, 0);
        step(0, 1, 1, 1, 4'd6, 1, 4'd0, 1, 0, 1);
        step(1, 0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0);
        step(1, 0, 1, 0, 4'd0, 1, 4'd0, 1, 1, 0);
        step(1, 0, 0, 0, 4'd0, 1, 4'd15, 0, 0, 0);

        // two-stage cascade: 8-bit down count 0,255,...,240,239,...
        cstep(0, 0, 0, 8'd0);
        for (int k = 0; k < 40; k++) begin
            cstep(1, 1, 1, 8'(256 - k));
        end
        cstep(1, 0, 1, 8'(256 - 40));

        repeat (3) @(posedge clk);
        if (main_q.size() != 0 || casc_q.size() != 0) begin
            n_total++;
            $display("FAIL drain pending main=%0d cascade=%0d want 0", main_q.size(), casc_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/down_cnt4_rle.md
DOWN_CNT4_RLE -- requirements
Module: down_cnt4_rle

Interface
REQ-001 Parameter WIDTH, default 4: counter and load-data width.
REQ-002 Port clk, in, 1: single clock; all state SHALL update on the rising edge.
REQ-003 Port R, in, 1: reset is synchronous and active-low (R=0 resets on the next rising clk).
REQ-004 Port ce, in, 1: count enable.
REQ-005 Port L, in, 1: parallel load strobe.
REQ-006 Port di, in, WIDTH: load value for Q and the reload register.
REQ-007 Port mode, in, 1: 0 = auto-reload, 1 = one-shot.
REQ-008 Port Q, out, WIDTH: current count, registered.
REQ-009 Port TC, out, 1: terminal count; combinational, Q==0.
REQ-010 Port CEO, out, 1: cascade enable; combinational, ce & TC & (state==RUN).
REQ-011 Port done, out, 1: one-shot expired flag, registered.

Function
REQ-012 Block SHALL hold reload register RLD[WIDTH] and a 2-state FSM {RUN, HALT}.
REQ-013 Per-edge priority SHALL be: reset > L > ce > hold.
REQ-014 L=1 SHALL set Q<=di, RLD<=di, state<=RUN, done<=0, regardless of ce or mode.
REQ-015 RUN, ce=1, Q!=0: Q<=Q-1, one step per enabled edge, no skipped values.
REQ-016 RUN, ce=1, Q==0, mode=0: Q<=RLD; state stays RUN.
REQ-017 RUN, ce=1, Q==0, mode=1: Q stays 0; state<=HALT; done<=1.
REQ-018 HALT: Q, RLD, and done SHALL hold until L=1 or reset; ce is ignored.
REQ-019 ce=0, L=0 SHALL hold all state.
REQ-020 mode SHALL be sampled only at the zero event (REQ-016/017); changes at other times have no effect.
REQ-021 RLD=0 in auto-reload SHALL give divide-by-1 (Q stays 0, CEO=ce each cycle).
REQ-022 Auto-reload period SHALL be RLD+1 enabled cycles; CEO SHALL be high for exactly one enabled cycle per period.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH; no underflow below 0 except via reload.
REQ-024 L and ce high on the same edge SHALL load di with no decrement that cycle.

Reset
REQ-025 R=0 SHALL set Q=0, RLD=all-ones (2^WIDTH-1), state=RUN, done=0; outputs then TC=1, CEO=ce.
REQ-026 With defaults after reset, mode=0 and ce=1 SHALL sequence Q: 0,15,14,...,1,0,15 (free-running down counter).
REQ-027 Reset SHALL override L and ce on the same edge, including mid-count and in HALT.

Structure
REQ-028 Shared package SHALL hold the default WIDTH constant and the FSM state type {RUN, HALT}.
REQ-029 Single flat module; no sub-module. Cascading is done externally by chaining CEO to the next stage's ce.

Verification
REQ-030 Reset, mode=0, ce=1 for 17 cycles -> Q = 0,15,14,...,0,15; TC and CEO high only when Q==0.
REQ-031 L=1, di=5, then mode=0, ce=1 -> Q = 5,4,3,2,1,0,5; CEO high once per 6 cycles.
REQ-032 L=1, di=3, mode=1, ce=1 -> Q = 3,2,1,0; done=1 after the 0 cycle; Q holds 0; CEO=0 in HALT; then L=1, di=2 -> done=0, counting resumes.
REQ-033 ce toggled 1/0 while counting from 7 -> Q decrements only on ce=1 edges; CEO=0 whenever ce=0.
REQ-034 R=0 asserted at Q=4 with L=1, di=9 on the same edge -> Q=0, RLD=15, done=0 next cycle.
REQ-035 Two instances, WIDTH=4, CEO0->ce1, both reset, ce0=1 -> 8-bit down count 0,255,254,...; stage 1 steps only when stage 0 passes through 0.
